parking_entry_terminal: RTL and testbench

- Driver-side terminal for the parking gate controller: it generates `vehicle_arrival`, `code` and `vehicle_left`, and consumes the controller's handshake and status outputs.
- Accumulates decimal keypad digits into a binary PIN and presents it to the controller, holding `code_valid` until `code_ack`.
- Tracks the controller's verdict (`open_gate`, `wrong_ping`, `blocked_gate`) and reports the outcome to the driver's display.
- Sits between the physical keypad and loop sensors and the gate controller.

---
 rtl/parking_entry_terminal.sv | 207 ++++++++++++++++++++
 tb/tb_parking_entry_terminal.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_entry_terminal.sv
// rtl/parking_entry_terminal.sv - driver-side keypad/loop-sensor terminal for the parking gate controller
module parking_entry_terminal #(
  parameter int DIGITS       = 4,
  parameter int RESP_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sensor_arrive,
  input  logic        sensor_left,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        key_clear,
  input  logic        code_ack,
  input  logic        open_gate,
  input  logic        wrong_ping,
  input  logic        blocked_gate,
  input  logic        close_gate,
  output logic        vehicle_arrival,
  output logic [15:0] code,
  output logic        code_valid,
  output logic        vehicle_left,
  output logic        err_led,
  output logic        lock_led,
  output logic [2:0]  digit_cnt
);

  localparam int TW = $clog2(RESP_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_SEND    = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_PASSING = 3'd4;
  localparam logic [2:0] S_CLOSING = 3'd5;
  localparam logic [2:0] S_LOCKED  = 3'd6;

  localparam logic [2:0]    DIGITS_C = 3'(DIGITS);
  // Timer counts 0..RESP_TIMEOUT-1; the edge that sees the last value is the timeout.
  localparam logic [TW-1:0] T_LAST   = TW'(RESP_TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [15:0]   acc_q, acc_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [15:0]   code_q, code_d;
  logic          valid_q, valid_d;
  logic          arrival_q, arrival_d;
  logic          left_q, left_d;
  logic          err_q, err_d;
  logic          lock_q, lock_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          sensor_left_q;

  logic          key_ok;
  logic          timeout;
  logic [15:0]   acc_next;
  logic [2:0]    cnt_inc;

  assign key_ok   = key_valid && (key_digit <= 4'd9);
  assign timeout  = (timer_q == T_LAST);
  assign acc_next = (acc_q * 16'd10) + {12'd0, key_digit};
  assign cnt_inc  = cnt_q + 3'd1;

  // Next-state logic for the terminal sequence and all registered outputs.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    valid_d   = valid_q;
    arrival_d = arrival_q;
    left_d    = 1'b0;
    err_d     = err_q;
    lock_d    = lock_q;
    timer_d   = timer_q;

    case (state_q)
      S_IDLE: begin
        if (sensor_arrive) begin
          state_d   = S_COLLECT;
          arrival_d = 1'b1;
          acc_d     = '0;
          cnt_d     = '0;
        end
      end

      S_COLLECT: begin
        if (!sensor_arrive) begin
          // Driver backed away before finishing: silent return, no exit pulse.
          state_d   = S_IDLE;
          arrival_d = 1'b0;
        end else if (key_clear) begin
          acc_d = '0;
          cnt_d = '0;
        end else if (key_ok) begin
          acc_d = acc_next;
          cnt_d = cnt_inc;
          if (cnt_inc == DIGITS_C) begin
            state_d = S_SEND;
            code_d  = acc_next;
            valid_d = 1'b1;
            err_d   = 1'b0;
          end
        end
      end

      S_SEND: begin
        if (code_ack) begin
          valid_d = 1'b0;
          state_d = S_WAIT;
        end else if (timeout) begin
          valid_d = 1'b0;
          err_d   = 1'b1;
          state_d = S_COLLECT;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_WAIT: begin
        if (blocked_gate) begin
          state_d = S_LOCKED;
          lock_d  = 1'b1;
        end else if (open_gate) begin
          state_d = S_PASSING;
        end else if (wrong_ping || timeout) begin
          err_d   = 1'b1;
          state_d = S_COLLECT;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_PASSING: begin
        if (sensor_left && !sensor_left_q) begin
          left_d    = 1'b1;
          arrival_d = 1'b0;
          state_d   = S_CLOSING;
        end
      end

      S_CLOSING: begin
        if (close_gate) begin
          state_d = S_IDLE;
        end
      end

      S_LOCKED: begin
        if (!blocked_gate && !sensor_arrive) begin
          state_d   = S_IDLE;
          lock_d    = 1'b0;
          arrival_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Every state change restarts the response timer from zero.
    if (state_d != state_q) begin
      timer_d = '0;
    end
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      acc_q         <= '0;
      cnt_q         <= '0;
      code_q        <= '0;
      valid_q       <= 1'b0;
      arrival_q     <= 1'b0;
      left_q        <= 1'b0;
      err_q         <= 1'b0;
      lock_q        <= 1'b0;
      timer_q       <= '0;
      sensor_left_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      code_q        <= code_d;
      valid_q       <= valid_d;
      arrival_q     <= arrival_d;
      left_q        <= left_d;
      err_q         <= err_d;
      lock_q        <= lock_d;
      timer_q       <= timer_d;
      sensor_left_q <= sensor_left;
    end
  end

  assign vehicle_arrival = arrival_q;
  assign code            = code_q;
  assign code_valid      = valid_q;
  assign vehicle_left    = left_q;
  assign err_led         = err_q;
  assign lock_led        = lock_q;
  assign digit_cnt       = cnt_q;

endmodule

// File: tb/tb_parking_entry_terminal.sv
// tb/tb_parking_entry_terminal.sv - randomized self-checking bench for parking_entry_terminal
module tb_parking_entry_terminal;

  localparam int DIGITS       = 4;
  localparam int RESP_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sensor_arrive = 1'b0;
  logic        sensor_left = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_digit = 4'd0;
  logic        key_clear = 1'b0;
  logic        code_ack = 1'b0;
  logic        open_gate = 1'b0;
  logic        wrong_ping = 1'b0;
  logic        blocked_gate = 1'b0;
  logic        close_gate = 1'b0;
  logic        vehicle_arrival;
  logic [15:0] code;
  logic        code_valid;
  logic        vehicle_left;
  logic        err_led;
  logic        lock_led;
  logic [2:0]  digit_cnt;

  parking_entry_terminal #(.DIGITS(DIGITS), .RESP_TIMEOUT(RESP_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .sensor_arrive(sensor_arrive), .sensor_left(sensor_left),
    .key_valid(key_valid), .key_digit(key_digit), .key_clear(key_clear),
    .code_ack(code_ack), .open_gate(open_gate), .wrong_ping(wrong_ping),
    .blocked_gate(blocked_gate), .close_gate(close_gate),
    .vehicle_arrival(vehicle_arrival), .code(code), .code_valid(code_valid),
    .vehicle_left(vehicle_left), .err_led(err_led), .lock_led(lock_led),
    .digit_cnt(digit_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: digits typed so far, the PIN being entered, whether a car is present.
  int m_cnt = 0;
  int dig [DIGITS];
  int pin = 0;
  bit present = 1'b0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int d);
    key_digit = 4'(d);
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    if (d <= 9) m_cnt++;
    expect_eq("digit_cnt_after_key", digit_cnt, m_cnt);
  endtask

  task automatic random_digits();
    for (int i = 0; i < DIGITS; i++) dig[i] = $urandom_range(0, 9);
  endtask

  task automatic arrive_vehicle();
    sensor_arrive = 1'b1;
    step();
    m_cnt   = 0;
    present = 1'b1;
    expect_eq("arrival_rise", vehicle_arrival, 1);
    expect_eq("arrival_cnt", digit_cnt, 0);
  endtask

  task automatic clear_keys();
    key_clear = 1'b1;
    key_valid = 1'($urandom_range(0, 1));
    key_digit = 4'($urandom_range(0, 9));
    step();
    key_clear = 1'b0;
    key_valid = 1'b0;
    m_cnt = 0;
    expect_eq("clear_cnt", digit_cnt, 0);
  endtask

  // Types dig[] with optional ignored keys; the PIN is the positional decimal value.
  task automatic enter_pin(input bit noisy);
    pin = 0;
    for (int i = 0; i < DIGITS; i++) pin = pin * 10 + dig[i];
    for (int i = 0; i < DIGITS; i++) begin
      if (noisy && $urandom_range(0, 2) == 0) press($urandom_range(10, 15));
      press(dig[i]);
      if (i < DIGITS - 1) expect_eq("valid_early", code_valid, 0);
    end
    expect_eq("send_valid", code_valid, 1);
    expect_eq("send_code", code, pin);
    expect_eq("send_err_clear", err_led, 0);
  endtask

  task automatic ack_after(input int delay);
    for (int i = 0; i < delay; i++) begin
      step();
      expect_eq("hold_valid", code_valid, 1);
      expect_eq("hold_code", code, pin);
    end
    code_ack = 1'b1;
    step();
    code_ack = 1'b0;
    expect_eq("ack_drop", code_valid, 0);
  endtask

  task automatic send_timeout();
    repeat (RESP_TIMEOUT - 1) step();
    expect_eq("send_to_valid_held", code_valid, 1);
    step();
    expect_eq("send_to_valid", code_valid, 0);
    expect_eq("send_to_err", err_led, 1);
    expect_eq("send_to_cnt", digit_cnt, 0);
    m_cnt = 0;
  endtask

  task automatic verdict_wrong();
    repeat ($urandom_range(0, 5)) step();
    wrong_ping = 1'b1;
    step();
    wrong_ping = 1'b0;
    m_cnt = 0;
    expect_eq("wrong_err", err_led, 1);
    expect_eq("wrong_cnt", digit_cnt, 0);
    expect_eq("wrong_arrival", vehicle_arrival, 1);
  endtask

  task automatic verdict_timeout();
    repeat (RESP_TIMEOUT - 1) step();
    expect_eq("wait_to_early", err_led, 0);
    step();
    m_cnt = 0;
    expect_eq("wait_to_err", err_led, 1);
    expect_eq("wait_to_cnt", digit_cnt, 0);
  endtask

  task automatic verdict_open(input bit with_wrong, input bit next_car);
    repeat ($urandom_range(0, 3)) step();
    open_gate  = 1'b1;
    wrong_ping = with_wrong;
    step();
    open_gate  = 1'b0;
    wrong_ping = 1'b0;
    expect_eq("open_err", err_led, 0);
    expect_eq("open_lock", lock_led, 0);
    key_valid = 1'b1;
    key_digit = 4'($urandom_range(0, 9));
    step();
    key_valid = 1'b0;
    expect_eq("passing_keys_ignored", digit_cnt, m_cnt);
    expect_eq("passing_arrival", vehicle_arrival, 1);
    sensor_arrive = next_car;
    sensor_left   = 1'b1;
    step();
    expect_eq("left_pulse", vehicle_left, 1);
    expect_eq("left_arrival", vehicle_arrival, 0);
    step();
    sensor_left = 1'b0;
    expect_eq("left_one_cycle", vehicle_left, 0);
    repeat ($urandom_range(0, 3)) step();
    close_gate = 1'b1;
    step();
    close_gate = 1'b0;
    expect_eq("closed_arrival", vehicle_arrival, 0);
    step();
    expect_eq("rearrival", vehicle_arrival, next_car);
    present = next_car;
    m_cnt   = 0;
    if (next_car) expect_eq("rearrival_cnt", digit_cnt, 0);
  endtask

  task automatic verdict_blocked();
    repeat ($urandom_range(0, 3)) step();
    blocked_gate = 1'b1;
    open_gate    = 1'($urandom_range(0, 1));
    wrong_ping   = 1'($urandom_range(0, 1));
    step();
    open_gate  = 1'b0;
    wrong_ping = 1'b0;
    expect_eq("lock_set", lock_led, 1);
    expect_eq("lock_err", err_led, 0);
    for (int i = 0; i < 3; i++) begin
      key_valid = 1'b1;
      key_digit = 4'($urandom_range(0, 9));
      step();
    end
    key_valid = 1'b0;
    expect_eq("lock_keys_ignored", digit_cnt, m_cnt);
    expect_eq("lock_no_send", code_valid, 0);
    sensor_arrive = 1'b0;
    step();
    expect_eq("lock_held", lock_led, 1);
    blocked_gate = 1'b0;
    step();
    expect_eq("lock_release", lock_led, 0);
    expect_eq("lock_arrival", vehicle_arrival, 0);
    present = 1'b0;
  endtask

  task automatic depart_in_collect();
    repeat ($urandom_range(0, DIGITS - 1)) press($urandom_range(0, 9));
    sensor_arrive = 1'b0;
    step();
    expect_eq("depart_arrival", vehicle_arrival, 0);
    expect_eq("depart_no_left", vehicle_left, 0);
    present = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) step();
    expect_eq("rst_arrival", vehicle_arrival, 0);
    expect_eq("rst_code", code, 0);
    expect_eq("rst_valid", code_valid, 0);
    expect_eq("rst_cnt", digit_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    step();
    expect_eq("idle_arrival", vehicle_arrival, 0);
    expect_eq("idle_err", err_led, 0);
    expect_eq("idle_lock", lock_led, 0);

    // 5,9,9,0 -> ack after two cycles -> open -> exit -> close
    arrive_vehicle();
    dig = '{5, 9, 9, 0};
    enter_pin(1'b0);
    expect_eq("pin_5990", code, 16'h1766);
    ack_after(2);
    verdict_open(1'b0, 1'b0);

    // 1,2,3,4 rejected, then 5,9,9,0 clears the error on send
    arrive_vehicle();
    dig = '{1, 2, 3, 4};
    enter_pin(1'b0);
    ack_after(1);
    verdict_wrong();
    dig = '{5, 9, 9, 0};
    enter_pin(1'b0);
    ack_after(0);
    verdict_open(1'b1, 1'b1);

    // 5,9 then clear, then 5,9,9,0 with an ignored 12 in the middle
    press(5);
    press(9);
    clear_keys();
    press(5);
    press(9);
    press(12);
    press(9);
    press(0);
    expect_eq("clear_code", code, 5990);
    expect_eq("clear_valid", code_valid, 1);
    send_timeout();

    // Blocked and open together
    dig = '{7, 0, 0, 3};
    enter_pin(1'b1);
    ack_after(1);
    verdict_blocked();

    // Random sessions
    for (int s = 0; s < 40; s++) begin
      int kind;
      if (!present) arrive_vehicle();
      kind = $urandom_range(0, 5);
      if (kind == 5) begin
        depart_in_collect();
      end else begin
        random_digits();
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, DIGITS - 1)) press($urandom_range(0, 9));
          clear_keys();
        end
        enter_pin($urandom_range(0, 1) == 1);
        case (kind)
          0: send_timeout();
          1: begin ack_after($urandom_range(0, 5)); verdict_wrong(); end
          2: begin ack_after($urandom_range(0, 5)); verdict_timeout(); end
          3: begin ack_after($urandom_range(0, 5));
                   verdict_open(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))); end
          default: begin ack_after($urandom_range(0, 5)); verdict_blocked(); end
        endcase
      end
    end

    // Asynchronous reset in the middle of SEND
    if (!present) arrive_vehicle();
    random_digits();
    enter_pin(1'b0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    expect_eq("async_rst_valid", code_valid, 0);
    expect_eq("async_rst_arrival", vehicle_arrival, 0);
    expect_eq("async_rst_code", code, 0);
    sensor_arrive = 1'b0;
    present = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
    expect_eq("post_rst_cnt", digit_cnt, 0);
    expect_eq("post_rst_arrival", vehicle_arrival, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
